// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the regfile write port, merging MEM/WB and long-unit results.
// Latency: 1 cycle from winning arbitration to wen/wr_addr_o/wr_data_o; buffered entries >= 2 cycles.
// Backpressure: lu_ready_o drops when the buffer is full; stall_o holds MEM/WB when the buffer starves.
//
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   pipe_wen_i/pipe_addr_i/pipe_data_i in-order MEM/WB result (no backpressure except stall_o)
//   lu_valid_i/lu_ready_o/lu_addr_i/lu_data_i  long-unit result handshake into the buffer
//   stall_o                            pipeline must hold MEM/WB; pipe_wen_i ignored while high
//   busy_o                             buffer non-empty or write pending
//   wen/wr_addr_o/wr_data_o            registered regfile write port
// Optional feature macro WB_FWD_EN adds rs1_addr_i/rs2_addr_i, fwd_rs1_hit_o/fwd_rs2_hit_o and
// fwd_data_o (shared by both source operands, since both forward the same write-port data).
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pipe_wen_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_addr_i,
    input  logic [31:0] lu_data_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        wen,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] wr_data_o
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        fwd_rs1_hit_o,
    output logic        fwd_rs2_hit_o,
    output logic [31:0] fwd_data_o
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SCNT_W = $clog2(STARVE_MAX) + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_ent_t;

    wb_ent_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SCNT_W-1:0]   starve_q, starve_d;
    logic                stall_q, stall_d;
    logic                wen_q, wen_d;
    logic [4:0]          wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic                non_empty;
    logic                push;
    logic                pipe_ok;
    logic                pop;
    logic                pipe_win;
    wb_ent_t             head;

    assign non_empty  = (count_q != '0);
    assign lu_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    // x0 results complete the handshake but are never stored.
    assign push       = lu_valid_i && lu_ready_o && (lu_addr_i != 5'd0);
    // A stalled pipe's result is re-presented later, so it never competes here.
    assign pipe_ok    = pipe_wen_i && (pipe_addr_i != 5'd0) && !stall_q;
    // Pop only from entries already stored: no same-cycle bypass from lu inputs.
    assign pop        = non_empty && (stall_q || !pipe_ok);
    assign pipe_win   = pipe_ok && !pop;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        starve_d  = starve_q;
        stall_d   = stall_q;
        wen_d     = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

        if (pop) begin
            wen_d     = 1'b1;
            wr_addr_d = head.addr;
            wr_data_d = head.data;
        end else if (pipe_win) begin
            wen_d     = 1'b1;
            wr_addr_d = pipe_addr_i;
            wr_data_d = pipe_data_i;
        end

        // Starvation tracking: the head losing to the pipe counts up; any pop or
        // an empty buffer resets it. Saturate so a long stall cannot wrap it.
        if (pop || !non_empty) begin
            starve_d = '0;
        end else if (pipe_win && (starve_q != SCNT_W'(STARVE_MAX - 1))) begin
            starve_d = starve_q + SCNT_W'(1);
        end

        // Stall rises on the loss that brings the count to STARVE_MAX and falls
        // once the forced pop has happened.
        if (stall_q && pop) begin
            stall_d = 1'b0;
        end
        if (non_empty && pipe_win && (starve_q == SCNT_W'(STARVE_MAX - 1))) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            wen_q     <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            wen_q     <= wen_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{addr: lu_addr_i, data: lu_data_i};
        end
    end

    assign stall_o   = stall_q;
    assign wen       = wen_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign busy_o    = non_empty | wen_q;

`ifdef WB_FWD_EN
    assign fwd_rs1_hit_o = wen_q && (wr_addr_q == rs1_addr_i) && (rs1_addr_i != 5'd0);
    assign fwd_rs2_hit_o = wen_q && (wr_addr_q == rs2_addr_i) && (rs2_addr_i != 5'd0);
    assign fwd_data_o    = wr_data_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a write scoreboard.
// Expected writes are queued when stimulus is driven and compared on every observed wen.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_wb_arbiter;

    logic        clk;
    logic        rstn;
    logic        pipe_wen_i;
    logic [4:0]  pipe_addr_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic        stall_o;
    logic        busy_o;
    logic        wen;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;
`ifdef WB_FWD_EN
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        fwd_rs1_hit_o;
    logic        fwd_rs2_hit_o;
    logic [31:0] fwd_data_o;
`endif

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_MAX(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .pipe_wen_i  (pipe_wen_i),
        .pipe_addr_i (pipe_addr_i),
        .pipe_data_i (pipe_data_i),
        .lu_valid_i  (lu_valid_i),
        .lu_ready_o  (lu_ready_o),
        .lu_addr_i   (lu_addr_i),
        .lu_data_i   (lu_data_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .wen         (wen),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o)
`ifdef WB_FWD_EN
        ,
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .fwd_rs1_hit_o (fwd_rs1_hit_o),
        .fwd_rs2_hit_o (fwd_rs2_hit_o),
        .fwd_data_o    (fwd_data_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [36:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Advance one cycle; every write seen must match the head of the scoreboard.
    task automatic tick();
        logic [36:0] e;
        @(posedge clk);
        #1;
        if (wen === 1'b1) begin
            check("sb_write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_write_addr_data", 64'({wr_addr_o, wr_data_o}), 64'(e));
            end
        end
    endtask

    task automatic idle();
        pipe_wen_i  = 1'b0;
        pipe_addr_i = 5'd0;
        pipe_data_i = 32'd0;
        lu_valid_i  = 1'b0;
        lu_addr_i   = 5'd0;
        lu_data_i   = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d);
        pipe_wen_i  = 1'b1;
        pipe_addr_i = a;
        pipe_data_i = d;
    endtask

    task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
        lu_valid_i = 1'b1;
        lu_addr_i  = a;
        lu_data_i  = d;
    endtask

    initial begin
        idle();
`ifdef WB_FWD_EN
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;
`endif
        rstn = 1'b1;
        #2 rstn = 1'b0;
        tick();
        tick();
        check("rst_wen", 64'(wen), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        check("rst_wr_data", 64'(wr_data_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        rstn = 1'b1;
        #1;
        check("rst_release_ready", 64'(lu_ready_o), 64'd1);

        // Reset in the middle of a write, with a buffered entry that must be lost.
        drive_pipe(5'd9, 32'h0000_0099);
        drive_lu(5'd12, 32'h0000_0012);
        expect_wr(5'd9, 32'h0000_0099);
        tick();
        check("midrst_wen_before", 64'(wen), 64'd1);
        idle();
        rstn = 1'b0;
        #1;
        check("midrst_wen", 64'(wen), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        tick();
        rstn = 1'b1;
        #1;
        check("midrst_ready", 64'(lu_ready_o), 64'd1);
        tick();
        tick();
        tick();
        check("midrst_no_write_busy", 64'(busy_o), 64'd0);

        // Pipe-only write, then hold of the write port when idle.
        drive_pipe(5'd5, 32'hDEAD_BEEF);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick();
        check("pipe_wen", 64'(wen), 64'd1);
        idle();
        tick();
        check("idle_wen", 64'(wen), 64'd0);
        check("idle_hold_addr", 64'(wr_addr_o), 64'd5);
        check("idle_hold_data", 64'(wr_data_o), 64'hDEAD_BEEF);

        // x0 filter on both sources.
        drive_pipe(5'd0, 32'h0000_1234);
        drive_lu(5'd0, 32'h0000_5678);
        #1;
        check("x0_ready", 64'(lu_ready_o), 64'd1);
        tick();
        check("x0_wen0", 64'(wen), 64'd0);
        idle();
        tick();
        check("x0_wen1", 64'(wen), 64'd0);
        check("x0_count_zero", 64'(busy_o), 64'd0);

        // Minimum latency from lu accept to wen is two cycles.
        drive_lu(5'd3, 32'h0000_0077);
        tick();
        check("lat_no_bypass", 64'(wen), 64'd0);
        idle();
        expect_wr(5'd3, 32'h0000_0077);
        tick();
        check("lat_wen", 64'(wen), 64'd1);
        tick();

        // Fill the buffer while the pipe keeps winning.
        for (int k = 0; k < 4; k++) begin
            drive_pipe(5'(10 + k), 32'h0000_00A0 + 32'(k));
            drive_lu(5'(1 + k), 32'h0000_00B0 + 32'(k));
            #1;
            check("fill_ready", 64'(lu_ready_o), 64'd1);
            expect_wr(5'(10 + k), 32'h0000_00A0 + 32'(k));
            tick();
        end
        check("full_ready_low", 64'(lu_ready_o), 64'd0);
        // Pipe idle: drain in order. A push offered while full is refused even
        // though the buffer pops in that same cycle.
        idle();
        drive_lu(5'd31, 32'h0000_00FF);
        for (int k = 0; k < 4; k++) begin
            expect_wr(5'(1 + k), 32'h0000_00B0 + 32'(k));
        end
        tick();
        check("drain_wen0", 64'(wen), 64'd1);
        idle();
        for (int k = 1; k < 4; k++) begin
            tick();
            check("drain_consecutive", 64'(wen), 64'd1);
        end
        tick();
        check("drain_done_wen", 64'(wen), 64'd0);
        check("full_push_refused", 64'(busy_o), 64'd0);
        check("fill_sb_empty", 64'(exp_q.size()), 64'd0);

        // Starvation: one buffered entry, pipe busy every cycle.
        drive_pipe(5'd21, 32'h0000_D100);
        drive_lu(5'd20, 32'h0000_00C0);
        expect_wr(5'd21, 32'h0000_D100);
        tick();
        lu_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_pipe(5'd22, 32'h0000_D200 + 32'(i));
            expect_wr(5'd22, 32'h0000_D200 + 32'(i));
            tick();
            check("starve_stall", 64'(stall_o), 64'(i == 7));
        end
        // Stalled cycle: the presented pipe result is ignored, the head is written.
        drive_pipe(5'd23, 32'h0000_00E0);
        expect_wr(5'd20, 32'h0000_00C0);
        tick();
        check("forced_pop_wen", 64'(wen), 64'd1);
        check("stall_drop", 64'(stall_o), 64'd0);
        expect_wr(5'd23, 32'h0000_00E0);
        tick();
        check("represent_wen", 64'(wen), 64'd1);
        idle();
        tick();
        check("starve_end_busy", 64'(busy_o), 64'd0);
        check("starve_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef WB_FWD_EN
        drive_pipe(5'd7, 32'h0000_0055);
        expect_wr(5'd7, 32'h0000_0055);
        tick();
        idle();
        rs1_addr_i = 5'd7;
        rs2_addr_i = 5'd0;
        #1;
        check("fwd_rs1_hit", 64'(fwd_rs1_hit_o), 64'd1);
        check("fwd_data", 64'(fwd_data_o), 64'h55);
        check("fwd_rs2_x0", 64'(fwd_rs2_hit_o), 64'd0);
        tick();
        check("fwd_rs1_nowen", 64'(fwd_rs1_hit_o), 64'd0);
`endif

        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
